gcd_host_ctrl: RTL

GCD_HOST_CTRL -- requirements
Module: gcd_host_ctrl

---
 rtl/gcd_host_pkg.sv | 29 ++
 rtl/gcd_done_detect.sv | 55 +++++
 rtl/gcd_host_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/gcd_host_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gcd_host_pkg
// Description : Shared state encoding, default parameters and sizing helper
//               for the GCD host controller.
// Revision    : 1.0 - initial release
// ============================================================================
package gcd_host_pkg;

    localparam int unsigned C_RST_CYCLES     = 2;
    localparam int unsigned C_START_CYCLES   = 6;
    localparam int unsigned C_STABLE_CYCLES  = 16;
    localparam int unsigned C_TIMEOUT_CYCLES = 1024;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET_CPU = 3'd1,
        ST_START     = 3'd2,
        ST_RUN       = 3'd3,
        ST_RESP      = 3'd4
    } state_t;

    // Bits needed to hold the values 0..max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gcd_done_detect.sv
`default_nettype none
// ============================================================================
// Module      : gcd_done_detect
// Description : Result-stability counter and job watchdog for the GCD host.
// Revision    : 1.0 - initial release
// ============================================================================
module gcd_done_detect
    import gcd_host_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = C_STABLE_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = C_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_active,
    input  logic        i_run,
    input  logic [31:0] i_result,
    output logic        done,
    output logic        timeout
);

    localparam int unsigned C_SW = cnt_width(STABLE_CYCLES);
    localparam int unsigned C_WW = cnt_width(TIMEOUT_CYCLES);

    logic [31:0]     r_prev;
    logic [C_SW-1:0] r_stable;
    logic [C_WW-1:0] r_wd;
    logic            w_same;

    assign w_same = (i_result == r_prev) && (i_result != 32'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev   <= '0;
            r_stable <= '0;
            r_wd     <= '0;
        end else begin
            r_prev <= i_result;
            if (!i_run || !w_same)
                r_stable <= '0;
            else if (r_stable != C_SW'(STABLE_CYCLES))
                r_stable <= r_stable + 1'b1;
            if (!i_active)
                r_wd <= '0;
            else if (r_wd != C_WW'(TIMEOUT_CYCLES))
                r_wd <= r_wd + 1'b1;
        end
    end

    // Both flags fire on the cycle whose closing edge makes the count reach its limit.
    assign done    = i_run && w_same && (r_stable >= C_SW'(STABLE_CYCLES - 1));
    assign timeout = i_active && (r_wd >= C_WW'(TIMEOUT_CYCLES - 1));

endmodule
`default_nettype wire

// File: rtl/gcd_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gcd_host_ctrl
// Description : Sequences one GCD job on an attached core: reset, start pulse,
//               completion/timeout detection and response handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module gcd_host_ctrl
    import gcd_host_pkg::*;
#(
    parameter int unsigned RST_CYCLES     = C_RST_CYCLES,
    parameter int unsigned START_CYCLES   = C_START_CYCLES,
    parameter int unsigned STABLE_CYCLES  = C_STABLE_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = C_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        cpu_rst_n,
    output logic        calc_start,
    output logic [31:0] gcd_a,
    output logic [31:0] gcd_b,
    input  logic [31:0] gcd_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_timeout,
    output logic        busy
);

    localparam int unsigned C_PH_MAX = (RST_CYCLES > START_CYCLES) ? RST_CYCLES : START_CYCLES;
    localparam int unsigned C_PH_W   = cnt_width(C_PH_MAX);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [C_PH_W-1:0] r_phase;
    logic [31:0]       r_gcd_a;
    logic [31:0]       r_gcd_b;
    logic [31:0]       r_rsp_result;
    logic              r_rsp_timeout;
    logic              w_accept;
    logic              w_zero_op;
    logic              w_done;
    logic              w_timeout;
    logic              w_active;
    logic              w_run;

    assign req_ready   = (r_state == ST_IDLE) && !rst;
    assign w_accept    = req_valid && req_ready;
    assign w_zero_op   = (req_a == 32'd0) || (req_b == 32'd0);
    assign w_run       = (r_state == ST_RUN);
    assign w_active    = (r_state == ST_START) || w_run;

    assign busy        = (r_state != ST_IDLE);
    assign rsp_valid   = (r_state == ST_RESP);
    assign cpu_rst_n   = w_active;
    assign calc_start  = (r_state == ST_RESET_CPU) || (r_state == ST_START);
    assign gcd_a       = r_gcd_a;
    assign gcd_b       = r_gcd_b;
    assign rsp_result  = r_rsp_result;
    assign rsp_timeout = r_rsp_timeout;

    gcd_done_detect #(
        .STABLE_CYCLES  (STABLE_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_done_detect (
        .clk      (clk),
        .rst      (rst),
        .i_active (w_active),
        .i_run    (w_run),
        .i_result (gcd_result),
        .done     (w_done),
        .timeout  (w_timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept)
                    w_state_nxt = w_zero_op ? ST_RESP : ST_RESET_CPU;
            end
            ST_RESET_CPU: begin
                if (r_phase == C_PH_W'(RST_CYCLES - 1))
                    w_state_nxt = ST_START;
            end
            ST_START: begin
                if (w_timeout)
                    w_state_nxt = ST_RESP;
                else if (r_phase == C_PH_W'(START_CYCLES - 1))
                    w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_done || w_timeout)
                    w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase       <= '0;
            r_gcd_a       <= '0;
            r_gcd_b       <= '0;
            r_rsp_result  <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            if (w_state_nxt != r_state)
                r_phase <= '0;
            else if ((r_state == ST_RESET_CPU) || (r_state == ST_START))
                r_phase <= r_phase + 1'b1;
            else
                r_phase <= '0;

            if (w_accept) begin
                r_gcd_a <= req_a;
                r_gcd_b <= req_b;
                if (w_zero_op) begin
                    r_rsp_result  <= req_a | req_b;
                    r_rsp_timeout <= 1'b0;
                end
            end

            // A stable result wins over a watchdog expiry on the same cycle.
            if (w_active && (w_done || w_timeout)) begin
                r_rsp_result  <= gcd_result;
                r_rsp_timeout <= !w_done;
            end
        end
    end

endmodule
`default_nettype wire
